// File: rtl/counter_seq_pkg.sv
// Shared types and helpers for the counter run-control sequencer.
`timescale 1ns / 1ps

package counter_seq_pkg;

    // Sequencer states; the encoding is visible on state_o.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_e;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    // Prescaler register width; never below one bit even when PRESCALE is 1.
    function automatic int unsigned prescale_width(input int unsigned prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/prescaler_tick.sv
// Free-running prescaler that emits a one-cycle tick every PRESCALE enabled cycles.
`timescale 1ns / 1ps

module prescaler_tick
    import counter_seq_pkg::*;
#(
    parameter int unsigned PRESCALE = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned PRESCALE_W = prescale_width(PRESCALE);
    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] r_cnt;
    logic                  w_at_last;

    assign w_at_last = (r_cnt == LAST);
    // A tick only exists on a cycle the prescaler actually advances.
    assign tick_o    = en_i && !clr_i && w_at_last;

    // Prescaler count: clear wins over enable, wraps to zero on the tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= w_at_last ? '0 : r_cnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Run-control sequencer: start/pause/stop/terminal-count handling around a prescaled counter.
`timescale 1ns / 1ps

module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH    = 6,
    parameter int unsigned PRESCALE = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             pause_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       state_o
);

    state_e           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_limit;
    logic             r_mode;
    logic             r_done;

    state_e           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_limit_nxt;
    logic             w_mode_nxt;
    logic             w_done_nxt;

    logic             w_in_run;
    logic             w_active;
    logic             w_start_ok;
    logic             w_clr;
    logic             w_tick;
    logic             w_terminal;

    assign w_in_run   = (r_state == RUN) || (r_state == PAUSE);
    // PAUSE with pause_i low advances in the same cycle so no cycle is lost on resume.
    assign w_active   = w_in_run && !pause_i && !stop_i;
    assign w_start_ok = ((r_state == IDLE) || (r_state == DONE)) && start_i && (limit_i != '0);
    assign w_clr      = stop_i || w_start_ok;
    assign w_terminal = w_tick && (r_count == r_limit);

    prescaler_tick #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en_i   (w_active),
        .clr_i  (w_clr),
        .tick_o (w_tick)
    );

    // Next-state decode in priority order: stop, pause, tick, start.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_limit_nxt = r_limit;
        w_mode_nxt  = r_mode;
        w_done_nxt  = 1'b0;

        if (stop_i) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (w_start_ok) begin
                        w_state_nxt = RUN;
                        w_count_nxt = '0;
                        w_limit_nxt = limit_i;
                        w_mode_nxt  = mode_i;
                    end
                end
                RUN, PAUSE: begin
                    if (pause_i) begin
                        w_state_nxt = PAUSE;
                    end else begin
                        w_state_nxt = RUN;
                        if (w_terminal) begin
                            w_done_nxt = 1'b1;
                            if (r_mode == MODE_RELOAD) begin
                                w_count_nxt = '0;
                            end else begin
                                // One-shot parks with the count showing the limit.
                                w_state_nxt = DONE;
                            end
                        end else if (w_tick) begin
                            w_count_nxt = r_count + WIDTH'(1);
                        end
                    end
                end
            endcase
        end
    end

    // State, count, latched run parameters and the registered done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_limit <= '0;
            r_mode  <= MODE_ONESHOT;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_limit <= w_limit_nxt;
            r_mode  <= w_mode_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign count_o = r_count;
    assign busy_o  = w_in_run;
    assign done_o  = r_done;
    assign state_o = r_state;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench: directed scenarios plus random stimulus against a behavioural model.
`timescale 1ns / 1ps

module tb_counter_sequencer;

    localparam int WIDTH = 6;
    localparam int P     = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic             stop_i = 1'b0;
    logic             pause_i = 1'b0;
    logic             mode_i = 1'b0;
    logic [WIDTH-1:0] limit_i = '0;
    logic [WIDTH-1:0] count_o;
    logic             busy_o;
    logic             done_o;
    logic [1:0]       state_o;

    int n_vec = 0;
    int n_err = 0;

    counter_sequencer #(
        .WIDTH    (WIDTH),
        .PRESCALE (P)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .stop_i  (stop_i),
        .pause_i (pause_i),
        .mode_i  (mode_i),
        .limit_i (limit_i),
        .count_o (count_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .state_o (state_o)
    );

    always #10 clk = ~clk;

    // Model: state 0 idle, 1 run, 2 pause, 3 done; m_el counts advancing cycles since start.
    // The count is derived from elapsed time rather than tracked step by step.
    int m_st   = 0;
    int m_el   = 0;
    int m_lim  = 0;
    int m_rel  = 0;
    int m_done = 0;
    bit m_ok   = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_st   <= 0;
            m_el   <= 0;
            m_lim  <= 0;
            m_rel  <= 0;
            m_done <= 0;
            m_ok   <= 1'b1;
        end else begin
            m_done <= 0;
            if (stop_i) begin
                m_st <= 0;
                m_el <= 0;
            end else if (m_st == 0 || m_st == 3) begin
                if (start_i && limit_i != 0) begin
                    m_st  <= 1;
                    m_el  <= 0;
                    m_lim <= int'(limit_i);
                    m_rel <= int'(mode_i);
                end
            end else if (pause_i) begin
                m_st <= 2;
            end else begin
                m_st <= 1;
                m_el <= m_el + 1;
                if ((m_el + 1) % ((m_lim + 1) * P) == 0) begin
                    m_done <= 1;
                    if (m_rel == 0) m_st <= 3;
                end
            end
        end
    end

    function automatic int model_count();
        if (m_st == 0) return 0;
        if (m_st == 3) return m_lim;
        return (m_el / P) % (m_lim + 1);
    endfunction

    // Per-cycle compare, sampled on the falling edge.
    always @(negedge clk) begin
        if (m_ok) begin
            int e_cnt;
            int e_busy;
            e_cnt  = model_count();
            e_busy = (m_st == 1 || m_st == 2) ? 1 : 0;
            n_vec++;
            if (int'(count_o) != e_cnt || int'(state_o) != m_st ||
                int'(busy_o) != e_busy || int'(done_o) != m_done) begin
                n_err++;
                $display("FAIL cycle t=%0t: count=%0d/%0d state=%0d/%0d busy=%0d/%0d done=%0d/%0d (got/exp)",
                         $time, count_o, e_cnt, state_o, m_st, busy_o, e_busy, done_o, m_done);
            end
        end
    end

    task automatic lit(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; returns at the first RUN cycle (T).
    task automatic go(input logic mode, input int lim);
        start_i = 1'b1;
        mode_i  = mode;
        limit_i = WIDTH'(lim);
        cyc(1);
        start_i = 1'b0;
    endtask

    initial begin
        int pulses;

        // 1. Reset and idle hold.
        repeat (3) @(posedge clk);
        #1;
        lit("rst count", int'(count_o), 0);
        lit("rst state", int'(state_o), 0);
        lit("rst busy", int'(busy_o), 0);
        lit("rst done", int'(done_o), 0);
        rst = 1'b0;
        cyc(100);
        lit("idle hold count", int'(count_o), 0);
        lit("idle hold state", int'(state_o), 0);

        // 2. One-shot, limit 3.
        go(1'b0, 3);
        lit("os T state", int'(state_o), 1);
        cyc(10);
        lit("os T+10 count", int'(count_o), 1);
        lit("model T+10 count", model_count(), 1);
        cyc(10);
        lit("os T+20 count", int'(count_o), 2);
        cyc(10);
        lit("os T+30 count", int'(count_o), 3);
        lit("os T+30 done", int'(done_o), 0);
        cyc(10);
        lit("os T+40 done", int'(done_o), 1);
        lit("os T+40 state", int'(state_o), 3);
        lit("os T+40 count", int'(count_o), 3);
        lit("os T+40 busy", int'(busy_o), 0);
        cyc(1);
        lit("os T+41 done", int'(done_o), 0);

        // 3. Auto-reload, limit 2, from DONE.
        go(1'b1, 2);
        cyc(20);
        lit("ar T+20 count", int'(count_o), 2);
        cyc(10);
        lit("ar T+30 count", int'(count_o), 0);
        lit("ar T+30 done", int'(done_o), 1);
        cyc(5);
        pulses = 0;
        for (int i = 0; i < 150; i++) begin
            cyc(1);
            if (done_o) pulses++;
        end
        lit("ar pulses in 150", pulses, 5);
        stop_i = 1'b1;
        cyc(1);
        stop_i = 1'b0;
        lit("ar stop state", int'(state_o), 0);

        // 4. One-shot with a 25-cycle pause from T+15.
        go(1'b0, 3);
        cyc(15);
        pause_i = 1'b1;
        cyc(5);
        lit("pause state", int'(state_o), 2);
        cyc(20);
        lit("pause count", int'(count_o), 1);
        lit("model pause count", model_count(), 1);
        pause_i = 1'b0;
        cyc(24);
        lit("pause T+64 done", int'(done_o), 0);
        cyc(1);
        lit("pause T+65 done", int'(done_o), 1);

        // 5. Stop on the terminal tick, then a zero-limit start.
        go(1'b0, 3);
        cyc(39);
        stop_i = 1'b1;
        cyc(1);
        stop_i = 1'b0;
        lit("stop term state", int'(state_o), 0);
        lit("stop term count", int'(count_o), 0);
        lit("stop term done", int'(done_o), 0);
        go(1'b0, 0);
        cyc(2);
        lit("zero limit state", int'(state_o), 0);

        // 6. Start ignored mid-run; then reset mid-run.
        go(1'b0, 3);
        cyc(3);
        start_i = 1'b1;
        limit_i = 6'd5;
        cyc(1);
        start_i = 1'b0;
        cyc(36);
        lit("restart ignored done", int'(done_o), 1);
        lit("restart ignored count", int'(count_o), 3);
        go(1'b0, 3);
        cyc(12);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        lit("midrun rst state", int'(state_o), 0);
        lit("midrun rst count", int'(count_o), 0);

        // Random phase.
        for (int i = 0; i < 4000; i++) begin
            start_i = ($urandom_range(0, 7) == 0);
            stop_i  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 11) == 0) pause_i = ~pause_i;
            mode_i  = 1'($urandom_range(0, 1));
            limit_i = ($urandom_range(0, 19) == 0) ? WIDTH'($urandom_range(0, 63))
                                                    : WIDTH'($urandom_range(0, 5));
            rst     = ($urandom_range(0, 599) == 0);
            cyc(1);
        end
        rst = 1'b0;
        start_i = 1'b0;
        stop_i = 1'b0;
        pause_i = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Run-control sequencer for the tutorial up-counter datapath. It owns a prescaled count register and sequences it through start, pause, stop and terminal-count events. One-shot and auto-reload modes are supported. It sits between user controls (buttons/registers) and the count display or consumer logic, and signals completion with a single-cycle pulse.

Parameters:
WIDTH, 6, width of count_o and limit_i
PRESCALE, 10, clock cycles per count step; legal range ≥1
PRESCALE_W, $clog2(PRESCALE) with minimum 1, prescaler register width (derived; do not override)

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
start_i  in  1  start request; level sampled each cycle; honoured only in IDLE/DONE
stop_i  in  1  abort; returns to IDLE and clears the count
pause_i  in  1  level; freezes count and prescaler while high
mode_i  in  1  0 = one-shot, 1 = auto-reload; latched at start
limit_i  in  WIDTH  terminal count; latched at start
count_o  out  WIDTH  current count value
busy_o  out  1  high in RUN or PAUSE
done_o  out  1  one-cycle pulse on terminal count
state_o  out  2  current FSM state encoding

Behaviour:
- Reset values: state = IDLE, count_o = 0, prescaler = 0, limit_q = 0, mode_q = 0, busy_o = 0, done_o = 0.
- Reset applies at the next edge from any state, including mid-run.
- Priority order: rst > stop_i > pause_i > tick > start_i.
- IDLE:
  - start_i=1 with limit_i≠0: latch limit_q and mode_q, clear count and prescaler, go to RUN next cycle.
  - start_i=1 with limit_i=0: ignored; stay in IDLE.
- RUN:
  - Prescaler increments every cycle.
  - tick = (prescaler == PRESCALE-1). On tick, prescaler returns to 0.
  - On tick with count_o < limit_q: count_o increments by 1.
  - On tick with count_o == limit_q: done_o = 1 for the following cycle only.
    - One-shot: go to DONE; count_o holds limit_q.
    - Auto-reload: count_o returns to 0; stay in RUN.
  - Each count value is held for PRESCALE cycles. Auto-reload period = (limit_q+1)·PRESCALE cycles.
  - PRESCALE=1 gives a tick every RUN cycle.
- RUN + pause_i=1: go to PAUSE. Count and prescaler freeze; any tick in that cycle is suppressed.
- PAUSE:
  - pause_i=0: return to RUN and resume from the frozen prescaler value, so no cycles are lost.
  - stop_i=1 overrides pause.
- stop_i in RUN, PAUSE or DONE: go to IDLE; count_o = 0, prescaler = 0, no done_o. A stop in the same cycle as the terminal tick suppresses done_o.
- DONE:
  - count_o holds limit_q; busy_o = 0.
  - start_i re-latches limit_i and mode_i and enters RUN from 0, using the same limit_i=0 rule as IDLE.
- start_i is ignored in RUN and PAUSE.
- limit_i and mode_i changes after start are ignored until the next start.
- count_o never exceeds limit_q and never wraps past 2^WIDTH-1, because limit_q ≤ 2^WIDTH-1.
- Unsigned arithmetic throughout; no X on outputs after the first reset edge.

Decomposition:
- Package counter_seq_pkg:
  - state typedef enum logic[1:0] {IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, DONE=2'b11}
  - MODE_ONESHOT=1'b0, MODE_RELOAD=1'b1
- Sub-module prescaler_tick, parameter PRESCALE:
  - inputs clk, rst, en_i, clr_i; output tick_o.
  - Counts while en_i is high; clr_i has priority over en_i.
- The top level holds the FSM, limit/mode latches and the count register.

Test Plan:
(PRESCALE=10, WIDTH=6, 20 ns clock; cycle T = first cycle in RUN)
1. rst high for 3 edges from an unknown state -> count_o=0, state_o=00, busy_o=0, done_o=0. Then rst low with no start -> outputs unchanged for 100 cycles.
2. One-shot, limit_i=3, start_i for 1 cycle -> count_o=1 at T+10, 2 at T+20, 3 at T+30. done_o=1 only at T+40, state_o=11, count_o stays 3, busy_o=0.
3. Auto-reload, limit_i=2 -> count_o sequence 0,1,2,0,… each value held 10 cycles. done_o pulses every 30 cycles; exactly 5 pulses in 150 cycles.
4. One-shot, limit_i=3, pause_i high for 25 cycles starting at T+15 -> count_o stays 1 throughout the pause. done_o arrives at T+65 (40+25).
5. stop_i asserted on the terminal-tick cycle (T+39, limit_i=3) -> state IDLE, count_o=0, done_o never asserts. Then start_i with limit_i=0 -> stays IDLE.
6. start_i pulsed during RUN with a new limit_i=5 -> ignored; run terminates at 3. rst pulse at T+12 -> next cycle IDLE, count_o=0.
